lsu: RTL and testbench

Load/store unit sitting directly downstream of the instruction decoder. It accepts one memory operation per request, described by the decoder's `mem_write` and 3-bit `mem_op` fields together with the ALU-computed address and rs2 data. It drives a word-wide valid/ready data-memory bus and returns sign- or zero-extended load data for writeback. It holds the core (`busy`) until the access completes.

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_if.sv | 25 ++
 rtl/lsu_align.sv | 47 ++++
 rtl/lsu.sv | 126 ++++++++++++
 tb/tb_lsu.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: mem_op encodings, FSM states
// and the access-size decode used by the alignment logic.
package lsu_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } lsu_size_t;

    function automatic lsu_size_t op_size(input logic [1:0] sz);
        case (sz)
            2'b00:   op_size = SZ_B;
            2'b01:   op_size = SZ_H;
            2'b10:   op_size = SZ_W;
            default: op_size = SZ_X;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Word-wide data-memory bus between the LSU (master) and memory (slave).
// A request transfers on a cycle where mem_valid & mem_ready are both high;
// once mem_valid is raised the master holds it and all request fields stable
// until that cycle. mem_ack (with mem_rdata/mem_err) ends the access later.
interface lsu_if #(parameter int ADDR_W = 32);
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wen;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              mem_err;

    modport master (
        output mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
        input  mem_ready, mem_ack, mem_rdata, mem_err
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
        output mem_ready, mem_ack, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobes/replication, load shift and
// extension, and the illegal/misaligned access check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic        write,
    input  logic [2:0]  op,
    input  logic [1:0]  a,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata_rep,
    output logic [31:0] ldata,
    output logic        illegal
);
    lsu_size_t   sz;
    logic [31:0] shifted;

    always_comb begin
        sz        = op_size(op[1:0]);
        shifted   = rdata >> {a, 3'b000};
        wstrb     = 4'b0000;
        wdata_rep = wdata;
        ldata     = shifted;
        illegal   = 1'b0;
        case (sz)
            SZ_B: begin
                wstrb     = 4'b0001 << a;
                wdata_rep = {4{wdata[7:0]}};
                ldata     = {{24{shifted[7] & ~op[2]}}, shifted[7:0]};
            end
            SZ_H: begin
                wstrb     = 4'b0011 << a;
                wdata_rep = {2{wdata[15:0]}};
                ldata     = {{16{shifted[15] & ~op[2]}}, shifted[15:0]};
                illegal   = a[0];
            end
            // op[2] set on a word size is the undefined 110 encoding
            SZ_W: begin
                wstrb   = 4'b1111;
                illegal = (a != 2'b00) | op[2];
            end
            default: illegal = 1'b1;
        endcase
        if (write & op[2]) illegal = 1'b1;
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one decoded memory op, runs a single registered
// bus access, and returns extended load data with a one-cycle response.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              busy,
    lsu_if.master             bus,
    output lsu_state_t        dbg_state
);
    lsu_state_t        state, state_nxt;
    logic              write_q;
    logic [2:0]        op_q;
    logic [1:0]        a_q;
    logic              mem_valid_q, mem_wen_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_wstrb_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              idle, accept;
    logic              al_write;
    logic [2:0]        al_op;
    logic [1:0]        al_a;
    logic [3:0]        al_wstrb;
    logic [31:0]       al_wdata, al_ldata;
    logic              al_illegal;

    assign idle   = (state == ST_IDLE);
    assign accept = idle & req_valid;

    // In IDLE the aligner looks at the incoming request; afterwards at the
    // captured op so load extension uses what was accepted.
    assign al_write = idle ? req_write     : write_q;
    assign al_op    = idle ? req_op        : op_q;
    assign al_a     = idle ? req_addr[1:0] : a_q;

    lsu_align u_align (
        .write     (al_write),
        .op        (al_op),
        .a         (al_a),
        .wdata     (req_wdata),
        .rdata     (bus.mem_rdata),
        .wstrb     (al_wstrb),
        .wdata_rep (al_wdata),
        .ldata     (al_ldata),
        .illegal   (al_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = al_illegal ? ST_RESP : ST_REQ;
            ST_REQ:  if (bus.mem_ready) state_nxt = ST_WAIT;
            ST_WAIT: if (bus.mem_ack) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_q      <= 1'b0;
            op_q         <= 3'b000;
            a_q          <= 2'b00;
            mem_valid_q  <= 1'b0;
            mem_wen_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                op_q    <= req_op;
                a_q     <= req_addr[1:0];
                if (al_illegal) begin
                    resp_err_q   <= 1'b1;
                    resp_rdata_q <= 32'h0;
                end else begin
                    mem_valid_q <= 1'b1;
                    mem_wen_q   <= req_write;
                    mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wstrb_q <= req_write ? al_wstrb : 4'b0000;
                    mem_wdata_q <= req_write ? al_wdata : 32'h0;
                end
            end
            if (state == ST_REQ && bus.mem_ready) mem_valid_q <= 1'b0;
            if (state == ST_WAIT && bus.mem_ack) begin
                resp_err_q   <= bus.mem_err;
                resp_rdata_q <= (bus.mem_err | write_q) ? 32'h0 : al_ldata;
            end
        end
    end

    assign req_ready     = idle;
    assign busy          = ~idle;
    assign resp_valid    = (state == ST_RESP);
    assign resp_rdata    = resp_rdata_q;
    assign resp_err      = resp_err_q;
    assign dbg_state     = state;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: stores, extended loads, illegal accesses, bus
// error, stalled bus, stray ack and reset in the middle of an access.
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  req_op = 3'b000;
    logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
    logic        req_ready, resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    lsu_state_t  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    lsu_if #(.ADDR_W(32)) bus ();

    lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .busy       (busy),
        .bus        (bus),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the LSU idle; returns at a negedge one cycle
    // after the response. Expected response data comes from exp_q.
    task automatic do_op(input string nm, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic ill, input logic [31:0] e_addr,
                         input logic [3:0] e_strb, input logic [31:0] e_wdata,
                         input int rdy_dly, input int ack_dly,
                         input logic [31:0] rdata, input logic err);
        logic [31:0] e_rd;
        e_rd = exp_q.pop_front();
        chk({nm, ".req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = wr; req_op = op;
        req_addr = addr; req_wdata = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        if (ill) begin
            chk({nm, ".ill_resp_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, ".ill_resp_err"}, 32'(resp_err), 32'd1);
            chk({nm, ".ill_rdata"}, resp_rdata, e_rd);
            chk({nm, ".ill_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        end else begin
            for (int i = 0; i <= rdy_dly; i++) begin
                chk({nm, ".mem_valid"}, 32'(bus.mem_valid), 32'd1);
                chk({nm, ".mem_addr"}, bus.mem_addr, e_addr);
                chk({nm, ".mem_wen"}, 32'(bus.mem_wen), 32'(wr));
                if (wr) begin
                    chk({nm, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(e_strb));
                    chk({nm, ".mem_wdata"}, bus.mem_wdata, e_wdata);
                end
                chk({nm, ".req_busy"}, 32'(busy), 32'd1);
                if (i == rdy_dly) bus.mem_ready = 1'b1;
                @(negedge clk);
            end
            bus.mem_ready = 1'b0;
            for (int i = 0; i <= ack_dly; i++) begin
                chk({nm, ".wait_mem_valid"}, 32'(bus.mem_valid), 32'd0);
                chk({nm, ".wait_busy"}, 32'(busy), 32'd1);
                chk({nm, ".wait_resp_valid"}, 32'(resp_valid), 32'd0);
                if (i == ack_dly) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata; bus.mem_err = err;
                end
                @(negedge clk);
            end
            bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; bus.mem_err = 1'b0;
            chk({nm, ".resp_valid"}, 32'(resp_valid), 32'd1);
            chk({nm, ".resp_err"}, 32'(resp_err), 32'(err));
            chk({nm, ".resp_rdata"}, resp_rdata, e_rd);
        end
        @(negedge clk);
        chk({nm, ".resp_pulse_end"}, 32'(resp_valid), 32'd0);
        chk({nm, ".idle_busy"}, 32'(busy), 32'd0);
        chk({nm, ".idle_mem_valid"}, 32'(bus.mem_valid), 32'd0);
        chk({nm, ".rdata_hold"}, resp_rdata, e_rd);
    endtask

    initial begin
        bus.mem_ready = 1'b0; bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0; bus.mem_err = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst.req_ready", 32'(req_ready), 32'd1);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_err", 32'(resp_err), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'h0);
        chk("rst.mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst.mem_wen", 32'(bus.mem_wen), 32'd0);
        chk("rst.mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
        chk("rst.mem_addr", bus.mem_addr, 32'h0);
        chk("rst.mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst.state", 32'(dbg_state), 32'(ST_IDLE));

        // Stores
        exp_q.push_back(32'h0);
        do_op("sw", 1, MOP_W, 32'h1000, 32'hDEADBEEF, 0, 32'h1000, 4'b1111, 32'hDEADBEEF, 0, 0, 32'h0, 0);
        exp_q.push_back(32'h0);
        do_op("sb", 1, MOP_B, 32'h1003, 32'h000000A5, 0, 32'h1000, 4'b1000, 32'hA5A5A5A5, 0, 0, 32'h0, 0);
        exp_q.push_back(32'h0);
        do_op("sh", 1, MOP_H, 32'h1002, 32'h00001234, 0, 32'h1000, 4'b1100, 32'h12341234, 0, 0, 32'h0, 0);

        // Loads from 0x1002 and other lanes of the same word
        exp_q.push_back(32'hFFFFFFF1);
        do_op("lb", 0, MOP_B, 32'h1002, 32'h0, 0, 32'h1000, 4'b0, 32'h0, 0, 0, 32'h80F17F00, 0);
        exp_q.push_back(32'h000000F1);
        do_op("lbu", 0, MOP_BU, 32'h1002, 32'h0, 0, 32'h1000, 4'b0, 32'h0, 0, 0, 32'h80F17F00, 0);
        exp_q.push_back(32'hFFFF80F1);
        do_op("lh", 0, MOP_H, 32'h1002, 32'h0, 0, 32'h1000, 4'b0, 32'h0, 0, 0, 32'h80F17F00, 0);
        exp_q.push_back(32'h000080F1);
        do_op("lhu", 0, MOP_HU, 32'h1002, 32'h0, 0, 32'h1000, 4'b0, 32'h0, 0, 0, 32'h80F17F00, 0);
        exp_q.push_back(32'h00000000);
        do_op("lb0", 0, MOP_B, 32'h1000, 32'h0, 0, 32'h1000, 4'b0, 32'h0, 0, 0, 32'h80F17F00, 0);
        exp_q.push_back(32'h00000080);
        do_op("lbu3", 0, MOP_BU, 32'h1003, 32'h0, 0, 32'h1000, 4'b0, 32'h0, 0, 0, 32'h80F17F00, 0);
        exp_q.push_back(32'hFFFFFF80);
        do_op("lb3", 0, MOP_B, 32'h1003, 32'h0, 0, 32'h1000, 4'b0, 32'h0, 0, 0, 32'h80F17F00, 0);

        // Stray ack while idle must not produce a response or alter results
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h12345678; bus.mem_err = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0; bus.mem_err = 1'b0;
        chk("stray.resp_valid", 32'(resp_valid), 32'd0);
        chk("stray.busy", 32'(busy), 32'd0);
        chk("stray.resp_rdata", resp_rdata, 32'hFFFFFF80);
        chk("stray.resp_err", 32'(resp_err), 32'd0);
        @(negedge clk);
        chk("stray.resp_valid2", 32'(resp_valid), 32'd0);

        // Illegal accesses: immediate error response, no bus traffic
        exp_q.push_back(32'h0);
        do_op("lw_mis1", 0, MOP_W, 32'h1001, 32'h0, 1, 32'h0, 4'b0, 32'h0, 0, 0, 32'h0, 0);
        exp_q.push_back(32'h0);
        do_op("lw_mis2", 0, MOP_W, 32'h1002, 32'h0, 1, 32'h0, 4'b0, 32'h0, 0, 0, 32'h0, 0);
        exp_q.push_back(32'h0);
        do_op("sh_mis", 1, MOP_H, 32'h1001, 32'h1234, 1, 32'h0, 4'b0, 32'h0, 0, 0, 32'h0, 0);
        exp_q.push_back(32'h0);
        do_op("sbu", 1, MOP_BU, 32'h1000, 32'h55, 1, 32'h0, 4'b0, 32'h0, 0, 0, 32'h0, 0);
        exp_q.push_back(32'h0);
        do_op("op011", 0, 3'b011, 32'h1000, 32'h0, 1, 32'h0, 4'b0, 32'h0, 0, 0, 32'h0, 0);
        exp_q.push_back(32'h0);
        do_op("op110", 0, 3'b110, 32'h1000, 32'h0, 1, 32'h0, 4'b0, 32'h0, 0, 0, 32'h0, 0);

        // Bus error returns zero data
        exp_q.push_back(32'h0);
        do_op("buserr", 0, MOP_W, 32'h2000, 32'h0, 0, 32'h2000, 4'b0, 32'h0, 0, 0, 32'h12345678, 1);

        // Stalled bus: ready after 2 cycles, ack after 3 more
        exp_q.push_back(32'hCAFEF00D);
        do_op("lw_slow", 0, MOP_W, 32'h2004, 32'h0, 0, 32'h2004, 4'b0, 32'h0, 2, 3, 32'hCAFEF00D, 0);
        exp_q.push_back(32'h0);
        do_op("sw_slow", 1, MOP_W, 32'h2008, 32'h01020304, 0, 32'h2008, 4'b1111, 32'h01020304, 1, 2, 32'h0, 0);

        // Reset while waiting for ack; the late ack is dropped
        chk("mid.req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_op = MOP_W;
        req_addr = 32'h3000; req_wdata = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid.mem_valid", 32'(bus.mem_valid), 32'd1);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        chk("mid.state_wait", 32'(dbg_state), 32'(ST_WAIT));
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid.state_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("mid.busy", 32'(busy), 32'd0);
        chk("mid.mem_valid0", 32'(bus.mem_valid), 32'd0);
        chk("mid.resp_valid", 32'(resp_valid), 32'd0);
        chk("mid.resp_rdata", resp_rdata, 32'h0);
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h77777777;
        @(negedge clk);
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        chk("mid.late_ack_resp", 32'(resp_valid), 32'd0);
        chk("mid.late_ack_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("mid.late_ack_resp2", 32'(resp_valid), 32'd0);

        exp_q.push_back(32'h000000AB);
        do_op("post_rst_lbu", 0, MOP_BU, 32'h3001, 32'h0, 0, 32'h3000, 4'b0, 32'h0, 0, 0, 32'h0000AB00, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
